// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into CHUNK-bit
// segments with one register stage each. A global advance signal moves the
// whole pipe or freezes it, so a stalled consumer back-pressures the producer
// without dropping or duplicating beats.

// One CHUNK-bit ripple segment; also exposes the carry into its top bit so the
// last segment can form signed overflow.
module pipelined_addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [CHUNK:0] c;

  // Full-adder ripple across the segment
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++)
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign s  = a ^ b ^ c[CHUNK-1:0];
  assign co = c[CHUNK];
  assign cm = c[CHUNK-1];
endmodule

module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = (CHUNK > 0) ? WIDTH / CHUNK : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  // Beat state carried between stages: operands (y already inverted for sub),
  // sum slices resolved so far, carry out of the last resolved slice, and the
  // carry into that slice's top bit.
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             m;
  } stg_t;

  logic [STAGES:0] vld_pipe;
  logic            adv;

  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];
  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stg_t             din, nxt, q;
    logic             v;
    logic [CHUNK-1:0] cs;
    logic             cco, ccm;

    if (k == 0) begin : g_first
      assign din.x = x;
      assign din.y = sub ? ~y : y;
      assign din.s = '0;
      assign din.c = sub | cin;
      assign din.m = 1'b0;
    end else begin : g_next
      assign din = g_stg[k-1].q;
    end

    pipelined_addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (din.x[k*CHUNK +: CHUNK]),
      .b  (din.y[k*CHUNK +: CHUNK]),
      .ci (din.c),
      .s  (cs),
      .co (cco),
      .cm (ccm)
    );

    // Merge this segment's slice and carries into the travelling beat
    always_comb begin
      nxt                   = din;
      nxt.s[k*CHUNK +: CHUNK] = cs;
      nxt.c                 = cco;
      nxt.m                 = ccm;
    end

    // Stage register: valid shifts on every advance, data only loads with a
    // real beat so an idle pipe keeps its last (or reset) value
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= 1'b0;
        q <= '0;
      end else if (adv) begin
        v <= vld_pipe[k];
        if (vld_pipe[k]) q <= nxt;
      end
    end

    assign vld_pipe[k+1] = v;
  end

  assign sum  = g_stg[STAGES-1].q.s;
  assign cout = g_stg[STAGES-1].q.c;
  assign ovf  = g_stg[STAGES-1].q.c ^ g_stg[STAGES-1].q.m;

  // Operand copies in the final stage have no consumer
  logic unused_last_ops;
  assign unused_last_ops = ^{g_stg[STAGES-1].q.x, g_stg[STAGES-1].q.y};
endmodule
